mat_row_server: RTL and testbench
=================================

Name: mat_row_server

Overview:
- Responder side of the triangular-inverter row-fetch interface.
- Holds one SIZE x SIZE complex double-precision matrix, loaded row by row from an upstream source.
- Answers the inverter's row-address requests with the addressed row one cycle later.
- Signals when a full matrix is resident; returns to fill mode on release.

Parameters:
SIZE, 16, matrix dimension (rows and complex elements per row)
WIDTH, 64, bits per real/imag component (IEEE-754 double)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
load_row_i  in  SIZE*2*WIDTH  row to store; element j at bits [j*2*WIDTH +: 2*WIDTH], real in low WIDTH bits, imag in high WIDTH bits
load_valid_i  in  1  load_row_i valid
load_ready_o  out  1  server accepts a load this cycle
matrix_ready_o  out  1  one-cycle pulse: full matrix resident (drives inverter start)
req_addr_i  in  $clog2(SIZE)  requested row index
req_valid_i  in  1  request strobe
row_o  out  SIZE*2*WIDTH  requested row data
row_addr_o  out  $clog2(SIZE)  index of row_o
row_valid_o  out  1  row_o/row_addr_o valid
release_i  in  1  consumer finished with the matrix; return to fill
busy_o  out  1  matrix resident and being served
err_o  out  1  sticky upper-triangle violation (optional feature only)

Behaviour:
- Interface: one clock, clk_i; synchronous active-high reset, rst_i.
- Reset: state FILL, load counter 0. load_ready_o=1 from the first cycle after reset. row_valid_o=0, row_o=0, row_addr_o=0, matrix_ready_o=0, busy_o=0, err_o=0. Memory contents are not cleared.
- FILL state:
  - load_ready_o=1.
  - On load_valid_i&&load_ready_o: mem[cnt]<=load_row_i; cnt++.
  - On accepting cnt==SIZE-1: cnt wraps to 0 and state goes to SERVE next cycle.
  - req_valid_i is ignored; no response is generated.
  - release_i is ignored.
- SERVE state:
  - load_ready_o=0; busy_o=1.
  - matrix_ready_o=1 for exactly the first SERVE cycle.
  - Each cycle with req_valid_i=1: next cycle row_valid_o=1, row_addr_o=req_addr_i, row_o=mem[req_addr_i]. Latency 1. One response per request. Full throughput, back-to-back. No backpressure.
  - Otherwise row_valid_o=0; row_o/row_addr_o hold their last values.
  - Address >= SIZE (non-power-of-2 SIZE): row_valid_o=1, row_o=0.
  - release_i: state goes to FILL next cycle. A request in the same cycle as release_i is still answered next cycle. A load presented in that cycle is not accepted (ready was 0).
- Reset mid-operation (FILL or SERVE): immediately returns to reset state. Partial loads are discarded and cnt=0. A pending response is dropped (row_valid_o=0).
- No arithmetic on data; rows are stored and returned bit-exact.

Optional Feature:
- Macro MAT_ROW_SERVER_TRI_CHECK_EN.
- Defined:
  - On each load into row i, any element j>i with a nonzero real or imag part sets err_o=1.
  - err_o is sticky until rst_i.
  - On read, elements j>row_addr_o are forced to zero in row_o, so the lower-triangular view is guaranteed.
- Undefined: err_o is tied to 0 and rows are returned exactly as loaded.

Decomposition:
- Shared package mat_inv_pkg:
  - complex_t packed struct {imag, real} of 2*WIDTH bits.
  - row_t = complex_t [SIZE-1:0].
  - Constants ROW_W=SIZE*2*WIDTH and ADDR_W=$clog2(SIZE).
  - State enum {FILL, SERVE}.
- Sub-module mat_row_mem: SIZE x ROW_W storage, one write port, one registered read port.
- The parent holds the FSM, counter, pulse generation and the optional check/mask.

Test Plan:
- Fill: reset, then load 16 rows with element (i,j)=(i+j/10)+j(i-j) for j<=i, else 0. After the 16th accept: matrix_ready_o pulses one cycle, load_ready_o=0, busy_o=1.
- Single read: req addr 5 -> next cycle row_valid_o=1, row_addr_o=5, row_o equals the loaded row 5 bit-exact. Requests 0..15 back-to-back -> 16 consecutive valid responses in order.
- Request during FILL: after 2 rows loaded, req addr 1 -> row_valid_o stays 0. Loading continues and completes normally.
- Release overlap: release_i with req addr 7 in the same cycle -> row 7 returned next cycle, state FILL, load_ready_o=1. A new 16-row load overwrites, and reads return the new data.
- Reset mid-load after 9 rows -> cnt=0. 16 further rows are required before matrix_ready_o pulses.
- Triangle check: row 2 loaded with element 4 = 1.0.
  - With MAT_ROW_SERVER_TRI_CHECK_EN: err_o=1 sticky, and a read of row 2 returns element 4 = 0.
  - Without it: err_o=0 and element 4 reads back 1.0.

Source files
------------

// File: rtl/mat_inv_pkg.sv
// Shared types and constants for the triangular-inverter row-fetch interface.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package mat_inv_pkg;

  localparam int SIZE   = 16;
  localparam int WIDTH  = 64;
  localparam int ROW_W  = SIZE * 2 * WIDTH;
  localparam int ADDR_W = $clog2(SIZE);

  // One complex element: real part in the low WIDTH bits, imag in the high.
  typedef struct packed {
    logic [WIDTH-1:0] im;
    logic [WIDTH-1:0] re;
  } complex_t;

  typedef complex_t [SIZE-1:0] row_t;

  typedef enum logic {
    FILL  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // True when any element right of the diagonal of row `idx` is nonzero.
  function automatic logic upper_nonzero(input row_t r, input logic [ADDR_W-1:0] idx);
    logic nz;
    nz = 1'b0;
    for (int j = 0; j < SIZE; j++) begin
      if (j > int'(idx) && r[j] != '0) nz = 1'b1;
    end
    return nz;
  endfunction

  // Zero every element right of the diagonal of row `idx`.
  function automatic row_t mask_upper(input row_t r, input logic [ADDR_W-1:0] idx);
    row_t m;
    m = r;
    for (int j = 0; j < SIZE; j++) begin
      if (j > int'(idx)) m[j] = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/mat_row_mem.sv
// Row storage: DEPTH x W array, one write port, one registered read port.
// Latency: read data valid the cycle after rd_en_i; holds when rd_en_i is low.
// Backpressure: none; every write and read strobe is taken immediately.
module mat_row_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 2048,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Registered read; out-of-range addresses return zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= (int'(rd_addr_i) < DEPTH) ? mem[rd_addr_i] : '0;
    end
  end

endmodule

// File: rtl/mat_row_server.sv
// Matrix row server: fills a SIZE x SIZE complex matrix, then answers row reads.
// Latency: one cycle from req_valid_i to row_valid_o; matrix_ready_o pulses on first SERVE cycle.
// Backpressure: loads accepted only in FILL (load_ready_o); responses cannot be stalled.
// Optional build macro MAT_ROW_SERVER_TRI_CHECK_EN: upper-triangle error flag and read mask.
module mat_row_server
  import mat_inv_pkg::*;
#(
  parameter  int SIZE  = mat_inv_pkg::SIZE,
  parameter  int WIDTH = mat_inv_pkg::WIDTH,
  localparam int RW    = SIZE * 2 * WIDTH,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [RW-1:0] load_row_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  output logic          matrix_ready_o,
  input  logic [AW-1:0] req_addr_i,
  input  logic          req_valid_i,
  output logic [RW-1:0] row_o,
  output logic [AW-1:0] row_addr_o,
  output logic          row_valid_o,
  input  logic          release_i,
  output logic          busy_o,
  output logic          err_o
);

  localparam logic [AW-1:0] LAST_ROW = AW'(SIZE - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic          first_q;
  logic          row_valid_q;
  logic [AW-1:0] row_addr_q;
  logic          load_acc;
  logic          rd_en;
  logic [RW-1:0] rd_data;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Next state plus load/read strobes; requests in FILL and release in FILL are ignored.
  always_comb begin
    state_d      = state_q;
    load_ready_o = 1'b0;
    busy_o       = 1'b0;
    load_acc     = 1'b0;
    rd_en        = 1'b0;
    case (state_q)
      FILL: begin
        load_ready_o = 1'b1;
        load_acc     = load_valid_i;
        if (load_valid_i && cnt_q == LAST_ROW) state_d = SERVE;
      end
      SERVE: begin
        busy_o = 1'b1;
        rd_en  = req_valid_i;
        if (release_i) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Load counter, ready pulse and response tagging.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      first_q     <= 1'b0;
      row_valid_q <= 1'b0;
      row_addr_q  <= '0;
    end else begin
      if (load_acc) cnt_q <= (cnt_q == LAST_ROW) ? '0 : cnt_q + 1'b1;
      first_q     <= (state_q == FILL) && (state_d == SERVE);
      row_valid_q <= rd_en;
      if (rd_en) row_addr_q <= req_addr_i;
    end
  end

  mat_row_mem #(
    .DEPTH (SIZE),
    .W     (RW),
    .AW    (AW)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (load_acc),
    .wr_addr_i (cnt_q),
    .wr_data_i (load_row_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (req_addr_i),
    .rd_data_o (rd_data)
  );

  assign matrix_ready_o = first_q;
  assign row_valid_o    = row_valid_q;
  assign row_addr_o     = row_addr_q;

`ifdef MAT_ROW_SERVER_TRI_CHECK_EN
  logic err_q;

  // Sticky flag: a loaded row carried data right of its diagonal.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (load_acc && upper_nonzero(row_t'(load_row_i), cnt_q)) err_q <= 1'b1;
  end

  assign err_o = err_q;
  // Mask keyed on the registered address so it tracks the held row.
  assign row_o = mask_upper(row_t'(rd_data), row_addr_q);
`else
  assign err_o = 1'b0;
  assign row_o = rd_data;
`endif

endmodule

// File: tb/tb_mat_row_server.sv
module tb_mat_row_server;
  import mat_inv_pkg::*;

  localparam int EW = 2 * WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic [ROW_W-1:0]  load_row;
  logic              load_valid;
  logic              load_ready;
  logic              matrix_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_valid;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_addr;
  logic              row_valid;
  logic              rel;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [ROW_W-1:0]  d;
  } resp_t;

  resp_t            sb[$];
  logic [ROW_W-1:0] exp_rd [SIZE];
  logic             exp_err;

  always #5 clk = ~clk;

  mat_row_server dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_row_i     (load_row),
    .load_valid_i   (load_valid),
    .load_ready_o   (load_ready),
    .matrix_ready_o (matrix_ready),
    .req_addr_i     (req_addr),
    .req_valid_i    (req_valid),
    .row_o          (row),
    .row_addr_o     (row_addr),
    .row_valid_o    (row_valid),
    .release_i      (rel),
    .busy_o         (busy),
    .err_o          (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    int k;
    k = 0;
    for (int j = SIZE - 1; j >= 0; j--) begin
      if (obs[j*EW +: EW] !== exp[j*EW +: EW]) k = j;
    end
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: element %0d got %h expected %h", tag, k, obs[k*EW +: EW], exp[k*EW +: EW]);
  endtask

  // Element (i,j) = (base + i + j/10) + j*(i-j) on and below the diagonal, zero above.
  function automatic logic [ROW_W-1:0] mk_row(input int i, input real base);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int j = 0; j <= i; j++) begin
      r[j*EW +: WIDTH]         = $realtobits(base + i + j / 10.0);
      r[j*EW + WIDTH +: WIDTH] = $realtobits(real'(i - j));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ROW_W-1:0] d);
    load_row   = d;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic req(input int a);
    resp_t r;
    r.a       = ADDR_W'(a);
    r.d       = exp_rd[a];
    sb.push_back(r);
    req_addr  = ADDR_W'(a);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Scoreboard: every response must match the oldest outstanding request.
  always @(negedge clk) begin
    resp_t r;
    if (row_valid === 1'b1) begin
      n_checks++;
      assert (sb.size() > 0) n_pass++;
      else $error("FAIL unexpected_resp: got row_valid=1 addr %0d, expected no response", row_addr);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        check("resp_addr", 64'(row_addr), 64'(r.a));
        check_row("resp_row", row, r.d);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    load_row   = '0;
    load_valid = 1'b0;
    req_addr   = '0;
    req_valid  = 1'b0;
    rel        = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_load_ready",   64'(load_ready),   64'd1);
    check("rst_busy",         64'(busy),         64'd0);
    check("rst_matrix_ready", 64'(matrix_ready), 64'd0);
    check("rst_row_valid",    64'(row_valid),    64'd0);
    check("rst_row_addr",     64'(row_addr),     64'd0);
    check("rst_err",          64'(err),          64'd0);
    check_row("rst_row", row, '0);

    // Fill pattern A; a request after two rows must be ignored.
    for (int i = 0; i < 2; i++) begin
      exp_rd[i] = mk_row(i, 0.0);
      load(exp_rd[i]);
    end
    req_addr  = 1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("fill_req_ignored", 64'(row_valid), 64'd0);
    for (int i = 2; i < SIZE - 1; i++) begin
      exp_rd[i] = mk_row(i, 0.0);
      load(exp_rd[i]);
    end
    check("pre_full_ready", 64'(matrix_ready), 64'd0);
    check("pre_full_load_ready", 64'(load_ready), 64'd1);
    exp_rd[SIZE-1] = mk_row(SIZE - 1, 0.0);
    load(exp_rd[SIZE-1]);
    check("full_matrix_ready", 64'(matrix_ready), 64'd1);
    check("full_load_ready",   64'(load_ready),   64'd0);
    check("full_busy",         64'(busy),         64'd1);
    tick();
    check("pulse_one_cycle", 64'(matrix_ready), 64'd0);
    check("serve_busy",      64'(busy),         64'd1);

    // Single read, then back-to-back sweep, then hold.
    req(5);
    for (int a = 0; a < SIZE; a++) req(a);
    tick();
    check("idle_row_valid", 64'(row_valid), 64'd0);
    check("hold_row_addr",  64'(row_addr),  64'(SIZE - 1));
    check_row("hold_row", row, exp_rd[SIZE-1]);

    // Release with overlapping request; a load offered then must be refused.
    req_addr   = 7;
    req_valid  = 1'b1;
    rel        = 1'b1;
    load_row   = {ROW_W{1'b1}};
    load_valid = 1'b1;
    begin
      resp_t r;
      r.a = 7;
      r.d = exp_rd[7];
      sb.push_back(r);
    end
    tick();
    req_valid  = 1'b0;
    rel        = 1'b0;
    load_valid = 1'b0;
    check("rel_load_ready", 64'(load_ready), 64'd1);
    check("rel_busy",       64'(busy),       64'd0);

    // Pattern B overwrites the matrix.
    for (int i = 0; i < SIZE; i++) begin
      exp_rd[i] = mk_row(i, 100.0);
      load(exp_rd[i]);
      if (i == SIZE - 2) check("b_not_early", 64'(matrix_ready), 64'd0);
    end
    check("b_matrix_ready", 64'(matrix_ready), 64'd1);
    req(3);
    req(12);
    req(0);
    tick();

    // Reset mid-load after 9 rows: a fresh 16 rows are needed.
    rel = 1'b1;
    tick();
    rel = 1'b0;
    for (int i = 0; i < 9; i++) load(mk_row(i, 200.0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_load_ready", 64'(load_ready), 64'd1);
    check("mid_rst_busy",       64'(busy),       64'd0);
    for (int i = 0; i < SIZE; i++) begin
      exp_rd[i] = mk_row(i, 300.0);
      load(exp_rd[i]);
      if (i == SIZE - 2) begin
        check("c_not_early", 64'(matrix_ready), 64'd0);
        check("c_not_busy",  64'(busy),         64'd0);
      end
    end
    check("c_matrix_ready", 64'(matrix_ready), 64'd1);
    req(4);
    req(9);
    tick();

    // Upper-triangle entry in row 2: element 4 = 1.0.
    rel = 1'b1;
    tick();
    rel = 1'b0;
`ifdef MAT_ROW_SERVER_TRI_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int i = 0; i < SIZE; i++) begin
      logic [ROW_W-1:0] d;
      d = mk_row(i, 0.0);
      exp_rd[i] = d;
      if (i == 2) begin
        d[4*EW +: WIDTH] = $realtobits(1.0);
        if (!exp_err) exp_rd[i] = d;
      end
      load(d);
      if (i == 2) check("tri_err_set", 64'(err), 64'(exp_err));
    end
    req(2);
    req(1);
    tick();
    check("tri_err_sticky", 64'(err), 64'(exp_err));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("tri_err_cleared", 64'(err), 64'd0);

    repeat (2) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
